// File: rtl/axi_mm_pkg.sv
// rtl/axi_mm_pkg.sv - shared AXI-MM link channel widths and FIFO defaults
package axi_mm_pkg;

  localparam int AR_DW         = 47;
  localparam int AW_DW         = 47;
  localparam int W_DW          = 39;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    CH_AR = 2'd0,
    CH_AW = 2'd1,
    CH_W  = 2'd2
  } axi_mm_chan_e;

  // Payload width of each receive channel FIFO feeding the slave-name mapper.
  function automatic int chan_dw(axi_mm_chan_e ch);
    case (ch)
      CH_AR:   return AR_DW;
      CH_AW:   return AW_DW;
      default: return W_DW;
    endcase
  endfunction

endpackage

// File: rtl/axi_mm_rx_chan_fifo_if.sv
// rtl/axi_mm_rx_chan_fifo_if.sv - link push and mapper-side head handshake
interface axi_mm_rx_chan_fifo_if #(
  parameter int DW = 47
);
  logic          rx_push_vld;
  logic [DW-1:0] rx_push_data;
  logic          user_vld;
  logic [DW-1:0] rxfifo_data;
  logic          user_ready;

  modport slave (
    input  rx_push_vld,
    input  rx_push_data,
    input  user_ready,
    output user_vld,
    output rxfifo_data
  );

  modport master (
    output rx_push_vld,
    output rx_push_data,
    output user_ready,
    input  user_vld,
    input  rxfifo_data
  );
endinterface

// File: rtl/axi_mm_fifo_ptr.sv
// rtl/axi_mm_fifo_ptr.sv - wrap-bit read/write pointers with full, empty and occupancy
module axi_mm_fifo_ptr #(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push_en,
  output logic          pop_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Full is judged on the pre-pop state, so a push into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_en = push_req && !full;
  assign pop_en  = pop_req && !empty;
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];
  assign count   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/axi_mm_rx_chan_fifo.sv
// rtl/axi_mm_rx_chan_fifo.sv - credit-returning receive FIFO for one AXI-MM link channel
module axi_mm_rx_chan_fifo
  import axi_mm_pkg::*;
#(
  parameter int DW    = AR_DW,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr,
  axi_mm_rx_chan_fifo_if.slave  rx,
  output logic                  tx_credit,
  output logic [AW:0]           fifo_count,
  output logic                  err_overflow
);

  logic          push_en;
  logic          pop_en;
  logic          full;
  logic          empty;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] mem [DEPTH];

  axi_mm_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk_wr),
    .rst      (rst_wr),
    .push_req (rx.rx_push_vld),
    .pop_req  (rx.user_ready),
    .push_en  (push_en),
    .pop_en   (pop_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty)
  );

  // Storage is deliberately left unreset; the head is only meaningful with user_vld.
  always_ff @(posedge clk_wr) begin
    if (push_en) mem[wr_addr] <= rx.rx_push_data;
  end

  assign rx.user_vld    = !empty;
  assign rx.rxfifo_data = mem[rd_addr];

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      tx_credit    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      tx_credit <= pop_en;
      if (rx.rx_push_vld && full) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_mm_rx_chan_fifo.sv
// tb/tb_axi_mm_rx_chan_fifo.sv - scoreboard bench for the receive channel FIFO
module tb_axi_mm_rx_chan_fifo;
  import axi_mm_pkg::*;

  localparam int DW    = AR_DW;
  localparam int DEPTH = DEFAULT_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_wr = 1'b0;
  logic          rst_wr;
  logic          tx_credit;
  logic [CW-1:0] fifo_count;
  logic          err_overflow;

  always #5 clk_wr = ~clk_wr;

  axi_mm_rx_chan_fifo_if #(.DW(DW)) rx ();

  axi_mm_rx_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_wr       (clk_wr),
    .rst_wr       (rst_wr),
    .rx           (rx),
    .tx_credit    (tx_credit),
    .fifo_count   (fifo_count),
    .err_overflow (err_overflow)
  );

  logic [DW-1:0] mq[$];
  logic          m_credit;
  logic          m_ovf;
  logic          drv_push;
  logic          drv_ready;
  logic [DW-1:0] drv_data;
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  function automatic void model_clear();
    mq.delete();
    m_credit = 1'b0;
    m_ovf    = 1'b0;
  endfunction

  // Reference behaviour of one clock edge for the inputs that were applied.
  function automatic void model_edge();
    logic pop;
    logic full;
    if (rst_wr) begin
      model_clear();
      return;
    end
    full = (mq.size() == DEPTH);
    pop  = drv_ready && (mq.size() != 0);
    if (pop) void'(mq.pop_front());
    if (drv_push) begin
      if (full) m_ovf = 1'b1;
      else      mq.push_back(drv_data);
    end
    m_credit = pop;
  endfunction

  task automatic drive(input logic push, input logic [DW-1:0] data, input logic ready);
    rx.rx_push_vld  = push;
    rx.rx_push_data = data;
    rx.user_ready   = ready;
    drv_push        = push;
    drv_data        = data;
    drv_ready       = ready;
  endtask

  task automatic step(input logic push, input logic [DW-1:0] data, input logic ready);
    @(posedge clk_wr);
    model_edge();
    #1;
    drive(push, data, ready);
    @(negedge clk_wr);
  endtask

  task automatic do_reset();
    @(posedge clk_wr);
    model_edge();
    #1;
    rst_wr = 1'b1;
    drive(1'b0, '0, 1'b0);
    @(posedge clk_wr);
    model_edge();
    #1;
    rst_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_wr = 1'b1;
    drive(1'b1, DW'('h55), 1'b0);
    model_clear();
    repeat (2) @(posedge clk_wr);
    @(negedge clk_wr);
    total_cnt++; if (rx.user_vld !== 1'b0) $display("FAIL reset_vld got %0b exp 0", rx.user_vld); else pass_cnt++;
    total_cnt++; if (fifo_count !== '0) $display("FAIL reset_count got %0d exp 0", fifo_count); else pass_cnt++;
    total_cnt++; if (tx_credit !== 1'b0) $display("FAIL reset_credit got %0b exp 0", tx_credit); else pass_cnt++;
    total_cnt++; if (err_overflow !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", err_overflow); else pass_cnt++;
    @(posedge clk_wr);
    #1;
    rst_wr = 1'b0;
    drive(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    total_cnt++; if (fifo_count !== '0) $display("FAIL reset_push_ignored got %0d exp 0", fifo_count); else pass_cnt++;
  endtask

  task automatic test_single();
    step(1'b1, DW'('h1234), 1'b0);
    total_cnt++; if (rx.user_vld !== 1'b0) $display("FAIL single_no_writethrough got %0b exp 0", rx.user_vld); else pass_cnt++;
    step(1'b0, '0, 1'b0);
    total_cnt++; if (rx.user_vld !== 1'b1) $display("FAIL single_vld got %0b exp 1", rx.user_vld); else pass_cnt++;
    total_cnt++; if (rx.rxfifo_data !== mq[0]) $display("FAIL single_data got %0h exp %0h", rx.rxfifo_data, mq[0]); else pass_cnt++;
    total_cnt++; if (fifo_count !== CW'(1)) $display("FAIL single_count got %0d exp 1", fifo_count); else pass_cnt++;
    total_cnt++; if (tx_credit !== 1'b0) $display("FAIL single_no_credit got %0b exp 0", tx_credit); else pass_cnt++;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    total_cnt++; if (tx_credit !== m_credit) $display("FAIL single_credit got %0b exp %0b", tx_credit, m_credit); else pass_cnt++;
    total_cnt++; if (fifo_count !== CW'(mq.size())) $display("FAIL single_drained got %0d exp %0d", fifo_count, mq.size()); else pass_cnt++;
    step(1'b0, '0, 1'b0);
    total_cnt++; if (tx_credit !== 1'b0) $display("FAIL single_credit_one_cycle got %0b exp 0", tx_credit); else pass_cnt++;
  endtask

  task automatic test_overflow_drain();
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'('h100 + i), 1'b0);
    step(1'b1, DW'('h1FF), 1'b0);
    step(1'b0, '0, 1'b0);
    total_cnt++; if (fifo_count !== CW'(DEPTH)) $display("FAIL ovf_count got %0d exp %0d", fifo_count, DEPTH); else pass_cnt++;
    total_cnt++; if (err_overflow !== m_ovf) $display("FAIL ovf_flag got %0b exp %0b", err_overflow, m_ovf); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      total_cnt++; if (rx.user_vld !== 1'b1) $display("FAIL drain_vld[%0d] got %0b exp 1", i, rx.user_vld); else pass_cnt++;
      total_cnt++; if (mq.size() == 0 || rx.rxfifo_data !== mq[0]) $display("FAIL drain_data[%0d] got %0h exp %0h", i, rx.rxfifo_data, (mq.size() != 0) ? mq[0] : '0); else pass_cnt++;
      total_cnt++; if (tx_credit !== m_credit) $display("FAIL drain_credit[%0d] got %0b exp %0b", i, tx_credit, m_credit); else pass_cnt++;
    end
    step(1'b0, '0, 1'b0);
    total_cnt++; if (tx_credit !== 1'b1 || m_credit !== 1'b1) $display("FAIL drain_last_credit got %0b exp 1", tx_credit); else pass_cnt++;
    total_cnt++; if (fifo_count !== '0 || rx.user_vld !== 1'b0) $display("FAIL drain_empty got count %0d vld %0b exp 0 0", fifo_count, rx.user_vld); else pass_cnt++;
    total_cnt++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", err_overflow); else pass_cnt++;
    step(1'b0, '0, 1'b0);
    total_cnt++; if (tx_credit !== 1'b0) $display("FAIL drain_credit_end got %0b exp 0", tx_credit); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'('h500 + i), 1'b0);
    step(1'b1, DW'('hABC), 1'b1);
    total_cnt++; if (err_overflow !== 1'b0) $display("FAIL fullpp_ovf_pre got %0b exp 0", err_overflow); else pass_cnt++;
    step(1'b0, '0, 1'b0);
    total_cnt++; if (fifo_count !== CW'(mq.size())) $display("FAIL fullpp_count got %0d exp %0d", fifo_count, mq.size()); else pass_cnt++;
    total_cnt++; if (err_overflow !== m_ovf) $display("FAIL fullpp_ovf got %0b exp %0b", err_overflow, m_ovf); else pass_cnt++;
    total_cnt++; if (tx_credit !== m_credit) $display("FAIL fullpp_credit got %0b exp %0b", tx_credit, m_credit); else pass_cnt++;
    while (mq.size() != 0) begin
      step(1'b0, '0, 1'b1);
      total_cnt++; if (rx.rxfifo_data !== mq[0]) $display("FAIL fullpp_data got %0h exp %0h", rx.rxfifo_data, mq[0]); else pass_cnt++;
      step(1'b0, '0, 1'b0);
    end
    total_cnt++; if (rx.user_vld !== 1'b0) $display("FAIL fullpp_dropped_beat got vld %0b exp 0", rx.user_vld); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'('h300 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'('h400 + i), 1'b1);
      total_cnt++; if (fifo_count !== CW'(mq.size())) $display("FAIL b2b_count[%0d] got %0d exp %0d", i, fifo_count, mq.size()); else pass_cnt++;
      total_cnt++; if (mq.size() == 0 || rx.rxfifo_data !== mq[0]) $display("FAIL b2b_data[%0d] got %0h exp %0h", i, rx.rxfifo_data, (mq.size() != 0) ? mq[0] : '0); else pass_cnt++;
      total_cnt++; if (tx_credit !== m_credit) $display("FAIL b2b_credit[%0d] got %0b exp %0b", i, tx_credit, m_credit); else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      total_cnt++; if (mq.size() == 0 || rx.rxfifo_data !== mq[0]) $display("FAIL b2b_tail[%0d] got %0h exp %0h", i, rx.rxfifo_data, (mq.size() != 0) ? mq[0] : '0); else pass_cnt++;
    end
    step(1'b0, '0, 1'b0);
    total_cnt++; if (fifo_count !== '0) $display("FAIL b2b_end_count got %0d exp 0", fifo_count); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, DW'('h600 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    total_cnt++; if (tx_credit !== 1'b1) $display("FAIL arst_pre_credit got %0b exp 1", tx_credit); else pass_cnt++;
    total_cnt++; if (fifo_count !== CW'(5)) $display("FAIL arst_pre_count got %0d exp 5", fifo_count); else pass_cnt++;
    #2;
    rst_wr = 1'b1;
    #1;
    total_cnt++; if (rx.user_vld !== 1'b0) $display("FAIL arst_vld got %0b exp 0", rx.user_vld); else pass_cnt++;
    total_cnt++; if (fifo_count !== '0) $display("FAIL arst_count got %0d exp 0", fifo_count); else pass_cnt++;
    total_cnt++; if (tx_credit !== 1'b0) $display("FAIL arst_credit got %0b exp 0", tx_credit); else pass_cnt++;
    drive(1'b1, DW'('h6FF), 1'b1);
    @(posedge clk_wr);
    model_edge();
    #1;
    rst_wr = 1'b0;
    drive(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    total_cnt++; if (tx_credit !== 1'b0) $display("FAIL arst_post_credit got %0b exp 0", tx_credit); else pass_cnt++;
    total_cnt++; if (fifo_count !== '0 || rx.user_vld !== 1'b0) $display("FAIL arst_post_empty got count %0d vld %0b exp 0 0", fifo_count, rx.user_vld); else pass_cnt++;
  endtask

  task automatic test_empty_ready();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      total_cnt++; if (rx.user_vld !== 1'b0 || fifo_count !== '0) $display("FAIL empty_rdy_state[%0d] got vld %0b count %0d exp 0 0", i, rx.user_vld, fifo_count); else pass_cnt++;
      total_cnt++; if (tx_credit !== 1'b0) $display("FAIL empty_rdy_credit[%0d] got %0b exp 0", i, tx_credit); else pass_cnt++;
    end
    step(1'b1, DW'('h777), 1'b0);
    step(1'b0, '0, 1'b0);
    total_cnt++; if (rx.rxfifo_data !== mq[0] || fifo_count !== CW'(1)) $display("FAIL empty_rdy_after got data %0h count %0d exp %0h 1", rx.rxfifo_data, fifo_count, mq[0]); else pass_cnt++;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    total_cnt++; if (tx_credit !== m_credit || fifo_count !== '0) $display("FAIL empty_rdy_pop got credit %0b count %0d exp %0b 0", tx_credit, fifo_count, m_credit); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow_drain();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    test_empty_ready();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
